controle_ula: RTL and testbench

Sequential issuing unit that sits in front of the 8-bit ALU and drives its operand/op-select inputs, then captures its result and zero flag. It accepts operation requests over a valid/ready handshake and returns one response per request over a second valid/ready handshake. Single-pass ops (AND, OR, ADD, SUB, SLT) take one ALU cycle. An unsigned 8×8 multiply (low byte) is built from eight iterated ALU adds.

---
 rtl/controle_ula.sv | 169 ++++++++++++++++
 tb/tb_controle_ula.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_ula.sv
// controle_ula: issuing unit in front of the 8-bit ALU.
// Accepts one request at a time, drives the ALU operand/op-select inputs,
// captures result and zero flag, and holds the response until consumed.
// MUL (low byte of unsigned 8x8) is built from eight shift-and-add passes
// through the ALU adder.
module controle_ula (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic [7:0] ula_entrada1,
   output logic [7:0] ula_entrada2,
   output logic [2:0] ula_sinal,
   input  logic [7:0] ula_saida,
   input  logic       ula_zero,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] resp_resultado,
   output logic       resp_zero,
   output logic       resp_erro
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EXECUTA  = 2'd1,
      MULT     = 2'd2,
      RESPOSTA = 2'd3
   } estado_t;

   estado_t    estado_q, estado_d;
   logic [2:0] op_q, op_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] mcand_q, mcand_d;
   logic [7:0] mplier_q, mplier_d;
   logic [2:0] cont_q, cont_d;
   logic [7:0] resultado_q, resultado_d;
   logic       zero_q, zero_d;
   logic       erro_q, erro_d;

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= OCIOSO;
         op_q        <= 3'b000;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         acc_q       <= 8'h00;
         mcand_q     <= 8'h00;
         mplier_q    <= 8'h00;
         cont_q      <= 3'd0;
         resultado_q <= 8'h00;
         zero_q      <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cont_q      <= cont_d;
         resultado_q <= resultado_d;
         zero_q      <= zero_d;
         erro_q      <= erro_d;
      end
   end

   // Next-state, register updates and ALU drive, defaults first.
   always_comb begin
      estado_d     = estado_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      cont_d       = cont_q;
      resultado_d  = resultado_q;
      zero_d       = zero_q;
      erro_d       = erro_q;
      ula_entrada1 = 8'h00;
      ula_entrada2 = 8'h00;
      ula_sinal    = OP_AND;

      unique case (estado_q)
         OCIOSO: begin
            if (req_valid) begin
               op_d = req_op;
               a_d  = req_a;
               b_d  = req_b;
               if (req_op <= OP_SLT) begin
                  estado_d = EXECUTA;
               end else if (req_op == OP_MUL) begin
                  acc_d    = 8'h00;
                  mcand_d  = req_a;
                  mplier_d = req_b;
                  cont_d   = 3'd0;
                  estado_d = MULT;
               end else begin
                  // Illegal op: answer straight away with the error flag.
                  resultado_d = 8'h00;
                  zero_d      = 1'b1;
                  erro_d      = 1'b1;
                  estado_d    = RESPOSTA;
               end
            end
         end

         EXECUTA: begin
            ula_entrada1 = a_q;
            ula_entrada2 = b_q;
            ula_sinal    = op_q;
            resultado_d  = ula_saida;
            zero_d       = ula_zero;
            erro_d       = 1'b0;
            estado_d     = RESPOSTA;
         end

         MULT: begin
            // One shift-and-add step: add the shifted multiplicand when the
            // current multiplier bit is set, otherwise add zero.
            ula_entrada1 = acc_q;
            ula_entrada2 = mplier_q[0] ? mcand_q : 8'h00;
            ula_sinal    = OP_ADD;
            acc_d        = ula_saida;
            mcand_d      = {mcand_q[6:0], 1'b0};
            mplier_d     = {1'b0, mplier_q[7:1]};
            cont_d       = cont_q + 3'd1;
            if (cont_q == 3'd7) begin
               resultado_d = ula_saida;
               zero_d      = ula_zero;
               erro_d      = 1'b0;
               estado_d    = RESPOSTA;
            end
         end

         RESPOSTA: begin
            if (resp_ready) begin
               estado_d = OCIOSO;
            end
         end

         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   // Handshake outputs decoded from state; response data straight from flops.
   always_comb begin
      req_ready      = (estado_q == OCIOSO) && !reset;
      resp_valid     = (estado_q == RESPOSTA);
      resp_resultado = resultado_q;
      resp_zero      = zero_q;
      resp_erro      = erro_q;
   end

endmodule

// File: tb/tb_controle_ula.sv
// Testbench for controle_ula: behavioural ALU attached to the ula_* port,
// directed scenarios plus randomized requests against a reference model.
module tb_controle_ula;

   logic       clock;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [7:0] ula_entrada1;
   logic [7:0] ula_entrada2;
   logic [2:0] ula_sinal;
   logic [7:0] ula_saida;
   logic       ula_zero;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] resp_resultado;
   logic       resp_zero;
   logic       resp_erro;

   int passed = 0;
   int total  = 0;

   controle_ula dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .ula_entrada1  (ula_entrada1),
      .ula_entrada2  (ula_entrada2),
      .ula_sinal     (ula_sinal),
      .ula_saida     (ula_saida),
      .ula_zero      (ula_zero),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_resultado(resp_resultado),
      .resp_zero     (resp_zero),
      .resp_erro     (resp_erro)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // The ALU the unit drives.
   always_comb begin
      case (ula_sinal)
         3'b000:  ula_saida = ula_entrada1 & ula_entrada2;
         3'b001:  ula_saida = ula_entrada1 | ula_entrada2;
         3'b010:  ula_saida = ula_entrada1 + ula_entrada2;
         3'b011:  ula_saida = ula_entrada1 - ula_entrada2;
         3'b100:  ula_saida = (ula_entrada1 < ula_entrada2) ? 8'hFF : 8'h00;
         default: ula_saida = 8'h00;
      endcase
      ula_zero = (ula_saida == 8'h00);
   end

   // Reference model: what a request should return, from plain arithmetic.
   function automatic logic [7:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int unsigned p;
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return 8'((int'(a) + int'(b)) % 256);
         3'd3: return 8'((int'(a) - int'(b) + 256) % 256);
         3'd4: return (a < b) ? 8'hFF : 8'h00;
         3'd5: begin p = a * b; return 8'(p % 256); end
         default: return 8'h00;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op);
      if (op == 3'd5) return 8;
      if (op >= 3'd6) return 0;
      return 1;
   endfunction

   // Issue one request and wait (bounded) for its response without consuming it.
   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic early,
                        output logic [7:0] res, output logic z, output logic e,
                        output int lat, output logic sinal_ok, output logic idle_ok);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(posedge clock); #1; n++;
      end
      req_valid  = 1'b1;
      req_op     = op;
      req_a      = a;
      req_b      = b;
      resp_ready = early;
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      lat      = 0;
      sinal_ok = 1'b1;
      while (resp_valid !== 1'b1 && lat < 20) begin
         if (op == 3'd5 && ula_sinal !== 3'b010) sinal_ok = 1'b0;
         @(posedge clock); #1; lat++;
      end
      idle_ok = (ula_entrada1 === 8'h00 && ula_entrada2 === 8'h00 && ula_sinal === 3'b000);
      res = resp_resultado;
      z   = resp_zero;
      e   = resp_erro;
   endtask

   task automatic consume(output logic v_after, output logic r_after);
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      v_after = resp_valid;
      r_after = req_ready;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_resultado !== 8'h00 ||
          resp_zero !== 1'b0 || resp_erro !== 1'b0 || ula_entrada1 !== 8'h00 ||
          ula_entrada2 !== 8'h00 || ula_sinal !== 3'b000)
         $display("FAIL reset_values: rdy=%b vld=%b res=%h z=%b e=%b u1=%h u2=%h s=%b required rdy=0 vld=0 all zero",
                  req_ready, resp_valid, resp_resultado, resp_zero, resp_erro, ula_entrada1, ula_entrada2, ula_sinal);
      else passed++;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      total++;
      if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", req_ready);
      else passed++;
   endtask

   task automatic test_single_pass;
      logic [2:0] ops[4] = '{3'd2, 3'd3, 3'd4, 3'd4};
      logic [7:0] as[4]  = '{8'h7F, 8'h35, 8'h02, 8'h09};
      logic [7:0] bs[4]  = '{8'h01, 8'h35, 8'h09, 8'h02};
      logic [7:0] exp_r[4] = '{8'h80, 8'h00, 8'hFF, 8'h00};
      logic       exp_z[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] res; logic z, e, sok, iok, va, ra; int lat;
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], as[i], bs[i], 1'b0, res, z, e, lat, sok, iok);
         total++;
         if (res !== exp_r[i] || z !== exp_z[i] || e !== 1'b0)
            $display("FAIL single_%0d: res=%h z=%b e=%b required res=%h z=%b e=0", i, res, z, e, exp_r[i], exp_z[i]);
         else passed++;
         total++;
         if (lat != 1) $display("FAIL single_lat_%0d: got %0d cycles required 1", i, lat);
         else passed++;
         consume(va, ra);
         total++;
         if (va !== 1'b0 || ra !== 1'b1) $display("FAIL single_consume_%0d: vld=%b rdy=%b required vld=0 rdy=1", i, va, ra);
         else passed++;
      end
   endtask

   task automatic test_mul;
      logic [7:0] res; logic z, e, sok, iok, va, ra; int lat;
      do_op(3'd5, 8'h0D, 8'h0B, 1'b0, res, z, e, lat, sok, iok);
      total++;
      if (res !== 8'h8F || z !== 1'b0 || e !== 1'b0)
         $display("FAIL mul_0d_0b: res=%h z=%b e=%b required res=8f z=0 e=0", res, z, e);
      else passed++;
      total++;
      if (lat != 8) $display("FAIL mul_lat: got %0d cycles required 8", lat);
      else passed++;
      total++;
      if (sok !== 1'b1) $display("FAIL mul_sinal: ula_sinal not 010 on some MULT cycle, required 010 always");
      else passed++;
      consume(va, ra);
      do_op(3'd5, 8'h10, 8'h10, 1'b0, res, z, e, lat, sok, iok);
      total++;
      if (res !== 8'h00 || z !== 1'b1 || e !== 1'b0)
         $display("FAIL mul_overflow: res=%h z=%b e=%b required res=00 z=1 e=0", res, z, e);
      else passed++;
      consume(va, ra);
   endtask

   task automatic test_illegal;
      logic [7:0] res; logic z, e, sok, iok, va, ra; int lat;
      do_op(3'd6, 8'hAA, 8'h55, 1'b0, res, z, e, lat, sok, iok);
      total++;
      if (res !== 8'h00 || z !== 1'b1 || e !== 1'b1)
         $display("FAIL illegal: res=%h z=%b e=%b required res=00 z=1 e=1", res, z, e);
      else passed++;
      total++;
      if (lat != 0 || iok !== 1'b1)
         $display("FAIL illegal_timing: lat=%0d ula_idle=%b required lat=0 ula_idle=1", lat, iok);
      else passed++;
      consume(va, ra);
   endtask

   task automatic test_backpressure;
      logic [7:0] res; logic z, e, sok, iok, va, ra; int lat; logic stable;
      do_op(3'd0, 8'hF0, 8'h3C, 1'b0, res, z, e, lat, sok, iok);
      total++;
      if (res !== 8'h30) $display("FAIL bp_value: got %h required 30", res);
      else passed++;
      // A competing request waits during backpressure.
      req_valid = 1'b1; req_op = 3'd2; req_a = 8'h01; req_b = 8'h01;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         if (resp_valid !== 1'b1 || resp_resultado !== 8'h30 || resp_zero !== 1'b0 ||
             resp_erro !== 1'b0 || req_ready !== 1'b0) stable = 1'b0;
      end
      total++;
      if (stable !== 1'b1) $display("FAIL bp_hold: response not held or req_ready high, required held 30 and rdy=0");
      else passed++;
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL bp_handshake: vld=%b rdy=%b required vld=0 rdy=1", resp_valid, req_ready);
      else passed++;
      @(posedge clock); #1;
      req_valid = 1'b0;
      total++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0)
         $display("FAIL bp_next_accept: rdy=%b vld=%b required rdy=0 vld=0", req_ready, resp_valid);
      else passed++;
      @(posedge clock); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_resultado !== 8'h02)
         $display("FAIL bp_next_result: vld=%b res=%h required vld=1 res=02", resp_valid, resp_resultado);
      else passed++;
      consume(va, ra);
   endtask

   task automatic test_reset_mid_mult;
      logic [7:0] res; logic z, e, sok, iok, va, ra; int lat;
      req_valid = 1'b1; req_op = 3'd5; req_a = 8'hFF; req_b = 8'hFF;
      @(posedge clock); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge clock); #1; end
      reset = 1'b1;
      #1;
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0 || ula_entrada1 !== 8'h00 ||
          ula_entrada2 !== 8'h00 || ula_sinal !== 3'b000 || resp_resultado !== 8'h00)
         $display("FAIL reset_mid_mult: vld=%b rdy=%b u1=%h u2=%h s=%b res=%h required all zero",
                  resp_valid, req_ready, ula_entrada1, ula_entrada2, ula_sinal, resp_resultado);
      else passed++;
      @(negedge clock);
      reset = 1'b0;
      do_op(3'd2, 8'h01, 8'h02, 1'b0, res, z, e, lat, sok, iok);
      total++;
      if (res !== 8'h03 || z !== 1'b0 || e !== 1'b0 || lat != 1)
         $display("FAIL add_after_reset: res=%h z=%b e=%b lat=%0d required res=03 z=0 e=0 lat=1", res, z, e, lat);
      else passed++;
      consume(va, ra);
   endtask

   task automatic test_random;
      logic [7:0] res; logic z, e, sok, iok, va, ra; int lat;
      logic [2:0] op; logic [7:0] a, b, er; logic ez, ee; logic early;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a = 8'($urandom); b = 8'($urandom);
         if (i % 8 == 0) b = a;
         early = 1'($urandom);
         er = ref_res(op, a, b);
         ee = (op >= 3'd6);
         ez = ee ? 1'b1 : (er == 8'h00);
         do_op(op, a, b, early, res, z, e, lat, sok, iok);
         total++;
         if (res !== er || z !== ez || e !== ee)
            $display("FAIL rand_%0d op=%0d a=%h b=%h: res=%h z=%b e=%b required res=%h z=%b e=%b",
                     i, op, a, b, res, z, e, er, ez, ee);
         else passed++;
         total++;
         if (lat != ref_lat(op) || iok !== 1'b1)
            $display("FAIL rand_timing_%0d op=%0d: lat=%0d idle=%b required lat=%0d idle=1", i, op, lat, iok, ref_lat(op));
         else passed++;
         consume(va, ra);
         total++;
         if (va !== 1'b0 || ra !== 1'b1)
            $display("FAIL rand_consume_%0d: vld=%b rdy=%b required vld=0 rdy=1", i, va, ra);
         else passed++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op     = 3'd0;
      req_a      = 8'h00;
      req_b      = 8'h00;
      resp_ready = 1'b0;
      test_reset();
      test_single_pass();
      test_mul();
      test_illegal();
      test_backpressure();
      test_reset_mid_mult();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
